// File: rtl/rpn_tokenizer.sv
`default_nettype none
// ============================================================================
// rpn_tokenizer: ASCII character stream -> RPN calculator number/operator tokens
// Revision: 1.0 - initial release
// ============================================================================
module rpn_tokenizer #(
  parameter int DATA_W = 32,
  parameter int CHAR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              char_stb,
  input  logic [CHAR_W-1:0] char_dat,
  output logic              char_ack,
  output logic              token_stb,
  output logic [DATA_W-1:0] token_dat,
  output logic              token_operator,
  input  logic              token_ack,
  output logic              error
);

  localparam logic [CHAR_W-1:0] CH_0   = CHAR_W'(8'h30);
  localparam logic [CHAR_W-1:0] CH_9   = CHAR_W'(8'h39);
  localparam logic [CHAR_W-1:0] CH_SP  = CHAR_W'(8'h20);
  localparam logic [CHAR_W-1:0] CH_TAB = CHAR_W'(8'h09);
  localparam logic [CHAR_W-1:0] CH_LF  = CHAR_W'(8'h0A);
  localparam logic [CHAR_W-1:0] CH_CR  = CHAR_W'(8'h0D);
  localparam logic [CHAR_W-1:0] CH_MUL = CHAR_W'(8'h2A);
  localparam logic [CHAR_W-1:0] CH_ADD = CHAR_W'(8'h2B);
  localparam logic [CHAR_W-1:0] CH_SUB = CHAR_W'(8'h2D);
  localparam logic [CHAR_W-1:0] CH_EQ  = CHAR_W'(8'h3D);

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_ACCUM       = 2'd1,
    S_EMIT        = 2'd2,
    S_EMIT_NUM_OP = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] token_dat_q, token_dat_d;
  logic [2:0]        pend_op_q, pend_op_d;
  logic              char_ack_q, char_ack_d;
  logic              token_stb_q, token_stb_d;
  logic              token_op_q, token_op_d;
  logic              error_q, error_d;

  logic              is_digit, is_sep, is_op, consume, overflow;
  logic [2:0]        op_code;
  logic [3:0]        digit;
  logic [DATA_W+3:0] acc_ext, acc_mul;
  logic [DATA_W-1:0] op_dat, pend_dat;

  always_comb begin
    is_sep  = 1'b0;
    is_op   = 1'b0;
    op_code = 3'b000;
    case (char_dat)
      CH_SP, CH_TAB, CH_LF, CH_CR: is_sep = 1'b1;
      CH_MUL: begin is_op = 1'b1; op_code = 3'b001; end
      CH_ADD: begin is_op = 1'b1; op_code = 3'b010; end
      CH_SUB: begin is_op = 1'b1; op_code = 3'b011; end
      CH_EQ:  begin is_op = 1'b1; op_code = 3'b100; end
      default: is_sep = 1'b0;
    endcase
  end

  // ASCII digits carry their value in the low nibble
  assign is_digit = (char_dat >= CH_0) && (char_dat <= CH_9);
  assign digit    = char_dat[3:0];
  assign acc_ext  = {4'd0, acc_q};
  assign acc_mul  = (acc_ext << 3) + (acc_ext << 1) + {{DATA_W{1'b0}}, digit};
  assign overflow = |acc_mul[DATA_W+3:DATA_W];
  assign op_dat   = {{(DATA_W-3){1'b0}}, op_code};
  assign pend_dat = {{(DATA_W-3){1'b0}}, pend_op_q};
  assign consume  = char_stb && !char_ack_q &&
                    ((state_q == S_IDLE) || (state_q == S_ACCUM));

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    pend_op_d   = pend_op_q;
    token_dat_d = token_dat_q;
    token_op_d  = token_op_q;
    token_stb_d = token_stb_q;
    char_ack_d  = consume;
    error_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (consume) begin
          if (is_digit) begin
            acc_d   = {{(DATA_W-4){1'b0}}, digit};
            state_d = S_ACCUM;
          end else if (is_op) begin
            token_stb_d = 1'b1;
            token_op_d  = 1'b1;
            token_dat_d = op_dat;
            state_d     = S_EMIT;
          end else if (!is_sep) begin
            error_d = 1'b1;
          end
        end
      end
      S_ACCUM: begin
        if (consume) begin
          if (is_digit) begin
            acc_d   = acc_mul[DATA_W-1:0];
            error_d = overflow;
          end else if (is_sep || is_op) begin
            token_stb_d = 1'b1;
            token_op_d  = 1'b0;
            token_dat_d = acc_q;
            pend_op_d   = op_code;
            state_d     = is_op ? S_EMIT_NUM_OP : S_EMIT;
          end else begin
            error_d = 1'b1;
            acc_d   = '0;
            state_d = S_IDLE;
          end
        end
      end
      S_EMIT: begin
        if (token_ack) begin
          token_stb_d = 1'b0;
          acc_d       = '0;
          state_d     = S_IDLE;
        end
      end
      S_EMIT_NUM_OP: begin
        // the terminating operator follows its number without dropping stb
        if (token_ack) begin
          token_op_d  = 1'b1;
          token_dat_d = pend_dat;
          state_d     = S_EMIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      pend_op_q   <= '0;
      token_dat_q <= '0;
      token_op_q  <= 1'b0;
      token_stb_q <= 1'b0;
      char_ack_q  <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      pend_op_q   <= pend_op_d;
      token_dat_q <= token_dat_d;
      token_op_q  <= token_op_d;
      token_stb_q <= token_stb_d;
      char_ack_q  <= char_ack_d;
      error_q     <= error_d;
    end
  end

  assign char_ack       = char_ack_q;
  assign token_stb      = token_stb_q;
  assign token_dat      = token_dat_q;
  assign token_operator = token_op_q;
  assign error          = error_q;

endmodule
`default_nettype wire

// File: tb/tb_rpn_tokenizer.sv
`default_nettype none
// Testbench for rpn_tokenizer: scoreboard of expected tokens popped on each accepted token.
module tb_rpn_tokenizer;
  localparam int DATA_W = 32;
  localparam int CHAR_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              char_stb = 1'b0;
  logic [CHAR_W-1:0] char_dat = '0;
  logic              char_ack;
  logic              token_stb;
  logic [DATA_W-1:0] token_dat;
  logic              token_operator;
  logic              token_ack = 1'b0;
  logic              error;

  always #5 clk = ~clk;

  rpn_tokenizer #(.DATA_W(DATA_W), .CHAR_W(CHAR_W)) dut (
    .clk(clk), .rst(rst), .char_stb(char_stb), .char_dat(char_dat),
    .char_ack(char_ack), .token_stb(token_stb), .token_dat(token_dat),
    .token_operator(token_operator), .token_ack(token_ack), .error(error)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_char_ack = 0;
  int n_err = 0;
  int n_tok = 0;
  logic [DATA_W:0] exp_q[$];

  bit auto_ack = 1'b0;
  int ack_delay = 1;
  int ack_cnt = 0;

  logic              prev_stb = 1'b0;
  logic              prev_ack = 1'b0;
  logic [DATA_W-1:0] prev_dat = '0;
  logic              prev_op = 1'b0;

  // token acceptor: raises token_ack ack_delay cycles after stb is seen
  always @(posedge clk) begin
    #1;
    if (token_ack) begin
      token_ack = 1'b0;
      ack_cnt = 0;
    end else if (auto_ack && token_stb === 1'b1) begin
      ack_cnt++;
      if (ack_cnt > ack_delay) token_ack = 1'b1;
    end else begin
      ack_cnt = 0;
    end
  end

  // scoreboard and stability monitor
  always @(negedge clk) begin
    logic [DATA_W:0] exp;
    if (char_ack === 1'b1) n_char_ack++;
    if (error === 1'b1) n_err++;
    if (token_stb === 1'b1 && prev_stb && !prev_ack) begin
      n_cmp++;
      if ({token_operator, token_dat} !== {prev_op, prev_dat}) begin
        n_bad++;
        $display("FAIL token_stable: got op=%0b dat=%0h, required op=%0b dat=%0h",
                 token_operator, token_dat, prev_op, prev_dat);
      end
    end
    if (token_stb === 1'b1 && token_ack) begin
      n_tok++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_token: got op=%0b dat=%0h, required no token",
                 token_operator, token_dat);
      end else begin
        exp = exp_q.pop_front();
        if ({token_operator, token_dat} !== exp) begin
          n_bad++;
          $display("FAIL token: got op=%0b dat=%0h, required op=%0b dat=%0h",
                   token_operator, token_dat, exp[DATA_W], exp[DATA_W-1:0]);
        end
      end
    end
    prev_stb = (token_stb === 1'b1);
    prev_ack = token_ack;
    prev_dat = token_dat;
    prev_op  = token_operator;
  end

  task automatic push_num(input logic [DATA_W-1:0] v);
    exp_q.push_back({1'b0, v});
  endtask

  task automatic push_op(input logic [2:0] c);
    exp_q.push_back({1'b1, {(DATA_W-3){1'b0}}, c});
  endtask

  task automatic send_char(input byte c);
    int t = 0;
    @(posedge clk); #1;
    char_stb = 1'b1;
    char_dat = c;
    do begin
      @(negedge clk);
      t++;
    end while (char_ack !== 1'b1 && t < 300);
    if (char_ack !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL char_ack_timeout: got no ack for 0x%0h, required ack", c);
    end
    @(posedge clk); #1;
    char_stb = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while ((exp_q.size() != 0 || token_stb === 1'b1) && t < 400) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_drain: got %0d tokens outstanding, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({char_ack, token_stb, token_dat, token_operator, error} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got ack=%b stb=%b dat=%0h op=%b err=%b, required all 0",
               char_ack, token_stb, token_dat, token_operator, error);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int c0 = n_char_ack;
    auto_ack = 1'b1;
    ack_delay = 1;
    send_str("12");
    push_num(12);
    send_str(" 34");
    push_num(34);
    push_op(3'b010);
    send_str("+");
    push_op(3'b100);
    send_str("=");
    wait_drain("basic");
    n_cmp++;
    if (n_char_ack - c0 != 7) begin
      n_bad++;
      $display("FAIL basic_char_acks: got %0d, required 7", n_char_ack - c0);
    end
  endtask

  task automatic test_num_op();
    int t = 0;
    push_num(7);
    push_op(3'b001);
    send_str("7*");
    @(posedge clk); #1;
    char_stb = 1'b1;
    char_dat = "3";
    do begin
      @(negedge clk);
      t++;
    end while (char_ack !== 1'b1 && t < 300);
    n_cmp++;
    if (char_ack !== 1'b1 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL num_op_stall: got ack=%b with %0d tokens pending, required ack with 0",
               char_ack, exp_q.size());
    end
    @(posedge clk); #1;
    char_stb = 1'b0;
    push_num(3);
    send_str(" ");
    wait_drain("num_op");
  endtask

  task automatic test_stall();
    int t = 0;
    ack_delay = 25;
    push_num(5);
    send_str("5 ");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_cmp++;
      if (token_stb !== 1'b1 || token_dat !== 32'd5 || token_operator !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_hold: got stb=%b dat=%0h op=%b, required stb=1 dat=5 op=0",
                 token_stb, token_dat, token_operator);
      end
    end
    while (token_ack !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    n_cmp++;
    if (token_stb !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_drop: got stb=%b, required 0", token_stb);
    end
    ack_delay = 1;
    wait_drain("stall");
  endtask

  task automatic test_invalid();
    int e0 = n_err;
    push_num(9);
    send_str("4x9 ");
    wait_drain("invalid");
    n_cmp++;
    if (n_err - e0 != 1) begin
      n_bad++;
      $display("FAIL invalid_errors: got %0d, required 1", n_err - e0);
    end
  endtask

  task automatic test_overflow();
    int e0 = n_err;
    send_str("429496729");
    n_cmp++;
    if (n_err != e0) begin
      n_bad++;
      $display("FAIL ovf_early_error: got %0d, required 0", n_err - e0);
    end
    push_num(32'd0);
    send_str("6");
    n_cmp++;
    if (n_err - e0 != 1) begin
      n_bad++;
      $display("FAIL ovf_error: got %0d, required 1", n_err - e0);
    end
    send_str(" ");
    wait_drain("ovf");
    e0 = n_err;
    push_num(32'hFFFF_FFFF);
    send_str("4294967295 ");
    wait_drain("max");
    n_cmp++;
    if (n_err != e0) begin
      n_bad++;
      $display("FAIL max_error: got %0d, required 0", n_err - e0);
    end
  endtask

  task automatic test_reset_mid();
    int k0;
    send_str("123");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({char_ack, token_stb, token_dat, token_operator, error} !== '0) begin
      n_bad++;
      $display("FAIL midreset_outputs: got ack=%b stb=%b dat=%0h op=%b err=%b, required all 0",
               char_ack, token_stb, token_dat, token_operator, error);
    end
    k0 = n_tok;
    send_str(" ");
    repeat (10) @(negedge clk);
    n_cmp++;
    if (n_tok != k0 || token_stb !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_no_token: got %0d tokens stb=%b, required 0 tokens stb=0",
               n_tok - k0, token_stb);
    end
    push_num(8);
    send_str("8 ");
    wait_drain("midreset");
  endtask

  task automatic test_back_to_back();
    ack_delay = 0;
    push_num(1);
    push_num(20);
    push_op(3'b011);
    push_num(0);
    send_str("1\t20-0\r\n  ");
    wait_drain("b2b");
    ack_delay = 1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_num_op();
    test_stall();
    test_invalid();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rpn_tokenizer.md
Name: rpn_tokenizer

Overview:
Upstream stage of the RPN calculator. Converts a stream of ASCII characters (e.g. from a UART receiver) into calculator tokens: decimal numbers are accumulated into 32-bit values, and operator characters are encoded into the calculator's 3-bit operator code. Output drives the calculator's input_stb/input_dat/input_operator/input_ack handshake directly.

Parameters:
DATA_W, 32, width of emitted number tokens; must equal the calculator data width.
CHAR_W, 8, width of the input character bus (ASCII).

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
char_stb  input  1  upstream character valid; held until char_ack is seen
char_dat  input  CHAR_W  ASCII character
char_ack  output  1  one-cycle pulse: the character was consumed
token_stb  output  1  token valid; held until token_ack
token_dat  output  DATA_W  number value, or operator code in [2:0] with upper bits 0
token_operator  output  1  1 = token_dat is an operator code, 0 = number
token_ack  input  1  calculator accepted the token (the calculator's input_ack)
error  output  1  one-cycle pulse on an invalid character or number overflow

Behaviour:
- Reset is synchronous and active-high (rst sampled on clk rising edge). Outputs: char_ack=0, token_stb=0, token_dat=0, token_operator=0, error=0. Internal: acc=0, pending_op cleared, state=IDLE. A mid-token reset drops any partial number or pending token without emitting it.
- Character classes:
  - digit: '0'-'9' (0x30-0x39)
  - separator: space 0x20, tab 0x09, LF 0x0A, CR 0x0D
  - operators: '*'=3'b001, '+'=3'b010, '-'=3'b011, '='=3'b100 (print/pop)
  - anything else is invalid.
- Character handshake:
  - A character is consumed on an edge where char_stb=1, char_ack=0, and the state is IDLE or ACCUM.
  - char_ack=1 is asserted for exactly the following cycle.
  - No character is consumed in the EMIT states, so upstream stalls.
- States:
  - IDLE:
    - digit: acc<=digit, go to ACCUM.
    - separator: ignored.
    - operator: load token (operator=1, dat=code), go to EMIT.
    - invalid: error pulse, stay in IDLE.
  - ACCUM:
    - digit: acc<=acc*10+digit, truncated to DATA_W.
    - separator: load number token from acc, go to EMIT.
    - operator: load number token, store pending_op, go to EMIT_NUM_OP.
    - invalid: error pulse, acc discarded, go to IDLE.
  - EMIT:
    - token_stb=1 with stable token_dat/token_operator.
    - On an edge where token_ack=1: token_stb<=0, acc<=0, go to IDLE.
  - EMIT_NUM_OP:
    - Same as EMIT for the number token.
    - On ack: load the pending operator token, go to EMIT. The number is always emitted before the operator that terminated it.
- Token handshake: token_stb rises the cycle after the terminating character is consumed (1-cycle latency). It is held until the first edge with token_ack=1, then dropped on that edge. Fields never change while token_stb=1.
- Overflow:
  - If acc*10+digit exceeds 2^DATA_W-1, pulse error.
  - The wrapped value is kept and accumulation continues; no saturation.
- Negative numbers are not supported: '-' is always the subtract operator.
- Zero-valued numbers are emitted normally.
- Simultaneous events: token_ack while token_stb=0 is ignored. char_stb during EMIT is not acked.
- Multiple separators produce no tokens. A number with no terminator stays in ACCUM indefinitely.

Test Plan:
- "12 34+=" one char at a time, ack each token 1 cycle after stb -> tokens in order: num 12, num 34, op 010, op 100; exactly 7 char_ack pulses.
- "7*" (no separator) -> num 7, then op 001. char_stb for a following '3' is not acked until both tokens are acked.
- token_ack held low for 20 cycles with "5 " -> token_stb stays 1 and token_dat stays 5 throughout. The token drops the edge after ack rises.
- "4x9 " -> error pulse on 'x', no token for 4, then num 9 emitted.
- "4294967296 " -> one error pulse on the final digit; number emitted as 0 (wrapped). "4294967295 " emits 0xFFFFFFFF with no error.
- rst asserted while in ACCUM after "123" -> all outputs 0. A following " " produces no token; "8 " then produces num 8.
